// File: rtl/kf8237_transfer_sequencer_pkg.sv
// Shared KF8237 definitions: sequencer state encoding and channel helpers.
package KF8237_Common_Package;

  typedef logic [2:0] state_t;

  localparam state_t SI    = 3'd0;
  localparam state_t S0    = 3'd1;
  localparam state_t S1    = 3'd2;
  localparam state_t S2    = 3'd3;
  localparam state_t S3    = 3'd4;
  localparam state_t S4    = 3'd5;
  localparam state_t SINIT = 3'd6;

  // One-hot channel select to channel number; zero maps to channel 0.
  function automatic logic [1:0] bit2num(input logic [3:0] onehot);
    logic [1:0] n;
    n = 2'd0;
    case (onehot)
      4'b0010: n = 2'd1;
      4'b0100: n = 2'd2;
      4'b1000: n = 2'd3;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/kf8237_transfer_sequencer_priority_resolver.sv
// Four-channel request arbiter with fixed or rotating priority.
module kf8237_priority_resolver
  import KF8237_Common_Package::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] request_i,
  input  logic       rotating_priority_i,
  input  logic       complete_i,
  input  logic [3:0] complete_select_i,
  output logic [3:0] grant_o
);

  // Channel number currently holding the highest priority.
  logic [1:0] ptr_q, ptr_d;

  // After a completed transfer in rotating mode, the channel just served
  // becomes lowest and the next one up becomes highest.
  always_comb begin
    ptr_d = ptr_q;
    if (complete_i && rotating_priority_i)
      ptr_d = bit2num(complete_select_i) + 2'd1;
  end

  // Pointer register; shares the falling edge with the rest of the block.
  always_ff @(negedge clock) begin
    if (reset) ptr_q <= 2'd0;
    else       ptr_q <= ptr_d;
  end

  // Scan channels starting from the highest-priority one; first hit wins.
  always_comb begin
    logic [1:0] base;
    logic [1:0] idx;
    logic       found;
    grant_o = 4'b0000;
    found   = 1'b0;
    base    = rotating_priority_i ? ptr_q : 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = base + 2'(i);
      if (!found && request_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/kf8237_transfer_sequencer.sv
// KF8237 single-transfer sequencer: state machine, channel latch, TC status
// and output decode around the priority resolver.
module kf8237_transfer_sequencer
  import KF8237_Common_Package::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       master_clear,
  input  logic [3:0] dma_request,
  input  logic [3:0] software_request,
  input  logic [3:0] request_mask,
  input  logic       rotating_priority,
  input  logic       controller_disable,
  input  logic [3:0] autoinitialize_config,
  input  logic       hold_acknowledge,
  input  logic       underflow,
  input  logic       read_status,
  output logic       hold_request,
  output logic [3:0] dma_acknowledge,
  output logic [3:0] transfer_register_select,
  output logic       address_enable,
  output logic       address_strobe,
  output logic       next_word,
  output logic       initialize_current_register,
  output logic       end_of_process,
  output logic [3:0] terminal_count_status,
  output logic [3:0] mask_set_on_tc
);

  state_t     state_q, state_d;
  logic [3:0] chan_q, chan_d;
  logic [3:0] tc_q, tc_d;
  logic [3:0] eff_req, grant;
  logic       clr, any_req, in_s4, tc_hit, auto_init;

  assign clr       = reset | master_clear;
  assign eff_req   = (dma_request & ~request_mask) | software_request;
  assign any_req   = |eff_req;
  assign in_s4     = (state_q == S4);
  assign tc_hit    = in_s4 & underflow;
  assign auto_init = |(chan_q & autoinitialize_config);

  kf8237_priority_resolver u_prio (
    .clock              (clock),
    .reset              (clr),
    .request_i          (eff_req),
    .rotating_priority_i(rotating_priority),
    .complete_i         (in_s4),
    .complete_select_i  (chan_q),
    .grant_o            (grant)
  );

  // Next-state logic; the channel is latched only when HLDA ends S0.
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    case (state_q)
      SI: if (any_req && !controller_disable) state_d = S0;
      S0: begin
        if (!any_req) state_d = SI;
        else if (hold_acknowledge) begin
          state_d = S1;
          chan_d  = grant;
        end
      end
      S1: state_d = S2;
      S2: state_d = S3;
      S3: state_d = S4;
      S4: state_d = (underflow && auto_init) ? SINIT : SI;
      default: state_d = SI;
    endcase
    if (state_d == SI) chan_d = 4'b0000;
  end

  // Read-status clears the sticky bits, but a simultaneous TC still lands.
  always_comb begin
    tc_d = read_status ? 4'b0000 : tc_q;
    if (tc_hit) tc_d = tc_d | chan_q;
  end

  // State, channel latch and TC registers; clear aborts without EOP.
  always_ff @(negedge clock) begin
    if (clr) begin
      state_q <= SI;
      chan_q  <= 4'b0000;
      tc_q    <= 4'b0000;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      tc_q    <= tc_d;
    end
  end

  assign hold_request                = (state_q != SI);
  assign transfer_register_select    = (state_q >= S1) ? chan_q : 4'b0000;
  assign dma_acknowledge             = (state_q >= S2 && state_q <= S4) ? chan_q : 4'b0000;
  assign address_enable              = (state_q >= S1 && state_q <= S4);
  assign address_strobe              = (state_q == S1);
  assign next_word                   = in_s4;
  assign initialize_current_register = (state_q == SINIT);
  assign end_of_process              = tc_hit;
  assign terminal_count_status       = tc_q;
  assign mask_set_on_tc              = (tc_hit && !auto_init) ? chan_q : 4'b0000;

endmodule

// File: tb/tb_kf8237_transfer_sequencer.sv
// Directed and randomized bench for kf8237_transfer_sequencer with a
// transaction-level reference model.
module tb_kf8237_transfer_sequencer;

  logic       clock = 1'b0;
  logic       reset, master_clear;
  logic [3:0] dma_request, software_request, request_mask;
  logic       rotating_priority, controller_disable;
  logic [3:0] autoinitialize_config;
  logic       hold_acknowledge, underflow, read_status;
  logic       hold_request;
  logic [3:0] dma_acknowledge, transfer_register_select;
  logic       address_enable, address_strobe, next_word;
  logic       initialize_current_register, end_of_process;
  logic [3:0] terminal_count_status, mask_set_on_tc;

  int checks = 0;
  int failures = 0;

  // Model state: highest-priority channel number and sticky TC bits.
  int         m_ptr = 0;
  logic [3:0] m_tc = 4'b0000;

  always #5 clock = ~clock;

  kf8237_transfer_sequencer dut (
    .clock                      (clock),
    .reset                      (reset),
    .master_clear               (master_clear),
    .dma_request                (dma_request),
    .software_request           (software_request),
    .request_mask               (request_mask),
    .rotating_priority          (rotating_priority),
    .controller_disable         (controller_disable),
    .autoinitialize_config      (autoinitialize_config),
    .hold_acknowledge           (hold_acknowledge),
    .underflow                  (underflow),
    .read_status                (read_status),
    .hold_request               (hold_request),
    .dma_acknowledge            (dma_acknowledge),
    .transfer_register_select   (transfer_register_select),
    .address_enable             (address_enable),
    .address_strobe             (address_strobe),
    .next_word                  (next_word),
    .initialize_current_register(initialize_current_register),
    .end_of_process             (end_of_process),
    .terminal_count_status      (terminal_count_status),
    .mask_set_on_tc             (mask_set_on_tc)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock of expected outputs: sample mid-cycle (rising edge), then
  // advance past the active falling edge before inputs change.
  task automatic cyc(input logic h, input logic [3:0] ack, input logic [3:0] sel,
                     input logic aen, input logic ads, input logic nw,
                     input logic ini, input logic eop, input logic [3:0] tc,
                     input logic [3:0] msk);
    @(posedge clock);
    chk("hold_request", {3'b0, hold_request}, {3'b0, h});
    chk("dma_acknowledge", dma_acknowledge, ack);
    chk("select", transfer_register_select, sel);
    chk("address_enable", {3'b0, address_enable}, {3'b0, aen});
    chk("address_strobe", {3'b0, address_strobe}, {3'b0, ads});
    chk("next_word", {3'b0, next_word}, {3'b0, nw});
    chk("init_current", {3'b0, initialize_current_register}, {3'b0, ini});
    chk("eop", {3'b0, end_of_process}, {3'b0, eop});
    chk("tc_status", terminal_count_status, tc);
    chk("mask_set_on_tc", mask_set_on_tc, msk);
    @(negedge clock);
    #1;
  endtask

  task automatic idle();
    cyc(0, 4'b0, 4'b0, 0, 0, 0, 0, 0, m_tc, 4'b0);
  endtask

  task automatic s0();
    cyc(1, 4'b0, 4'b0, 0, 0, 0, 0, 0, m_tc, 4'b0);
  endtask

  function automatic int pick(input logic [3:0] r, input int ptr, input bit rot);
    int base;
    base = rot ? ptr : 0;
    for (int k = 0; k < 4; k++)
      if (r[(base + k) % 4]) return (base + k) % 4;
    return 0;
  endfunction

  // Full transfer from SI back to SI with the expected waveform built from
  // the state sequence rules.
  task automatic xfer(input logic [3:0] dreq, input logic [3:0] msk, input logic [3:0] sw,
                      input bit rot, input logic [3:0] ai, input bit uf,
                      input int dly, input bit rs);
    logic [3:0] s;
    int w;
    w = pick((dreq & ~msk) | sw, m_ptr, rot);
    s = 4'b0001 << w;
    dma_request = dreq; request_mask = msk; software_request = sw;
    rotating_priority = rot; autoinitialize_config = ai;
    hold_acknowledge = (dly == 0);
    idle();
    for (int d = 0; d < dly; d++) s0();
    hold_acknowledge = 1'b1;
    s0();
    cyc(1, 4'b0, s, 1, 1, 0, 0, 0, m_tc, 4'b0);
    cyc(1, s, s, 1, 0, 0, 0, 0, m_tc, 4'b0);
    cyc(1, s, s, 1, 0, 0, 0, 0, m_tc, 4'b0);
    underflow = uf; read_status = rs;
    cyc(1, s, s, 1, 0, 1, 0, uf, m_tc, (uf && !ai[w]) ? s : 4'b0);
    m_tc = (rs ? 4'b0 : m_tc) | (uf ? s : 4'b0);
    if (rot) m_ptr = (w + 1) % 4;
    underflow = 0; read_status = 0; dma_request = 0; software_request = 0;
    hold_acknowledge = 0;
    if (uf && ai[w]) cyc(1, 4'b0, s, 0, 0, 0, 1, 0, m_tc, 4'b0);
    idle();
  endtask

  initial begin
    logic [3:0] dr, mk, sw;
    reset = 1; master_clear = 0; dma_request = 0; software_request = 0;
    request_mask = 0; rotating_priority = 0; controller_disable = 0;
    autoinitialize_config = 0; hold_acknowledge = 0; underflow = 0; read_status = 0;
    repeat (2) @(negedge clock);
    #1 reset = 0;
    idle();

    // ch2 alone, fixed priority, HLDA already high.
    xfer(4'b0100, 4'b0, 4'b0, 0, 4'b0, 0, 0, 0);

    // ch1 and ch3, rotating: alternate service.
    for (int i = 0; i < 4; i++) xfer(4'b1010, 4'b0, 4'b0, 1, 4'b0, 0, 0, 0);

    // ch0 underflow with and without auto-init.
    xfer(4'b0001, 4'b0, 4'b0, 0, 4'b0001, 1, 0, 0);
    xfer(4'b0001, 4'b0, 4'b0, 0, 4'b0000, 1, 1, 0);

    // Masked hardware request ignored; software request still wins.
    xfer(4'b0001, 4'b0001, 4'b0100, 0, 4'b0, 0, 0, 0);

    // Controller disabled: no service starts.
    controller_disable = 1; dma_request = 4'b0010;
    repeat (3) idle();
    controller_disable = 0; dma_request = 0;
    idle();

    // Move pointer, then withdraw in S0; pointer must be untouched.
    xfer(4'b0010, 4'b0, 4'b0, 1, 4'b0, 0, 0, 0);
    dma_request = 4'b0010; hold_acknowledge = 0; rotating_priority = 1;
    idle();
    s0();
    dma_request = 4'b0000;
    s0();
    idle();
    xfer(4'b1111, 4'b0, 4'b0, 1, 4'b0, 0, 0, 0);

    // Sticky bit 0 set, then read_status coincides with ch3 TC.
    xfer(4'b0001, 4'b0, 4'b0, 0, 4'b0, 1, 0, 0);
    xfer(4'b1000, 4'b0, 4'b0, 0, 4'b0, 1, 0, 1);

    // Rotate away from ch0 so the master clear's pointer reset is visible.
    xfer(4'b0001, 4'b0, 4'b0, 1, 4'b0, 0, 0, 0);

    // master_clear during S3: next edge everything idle, TC cleared, no EOP.
    dma_request = 4'b0010; hold_acknowledge = 1; rotating_priority = 0;
    idle();
    s0();
    cyc(1, 4'b0, 4'b0010, 1, 1, 0, 0, 0, m_tc, 4'b0);
    cyc(1, 4'b0010, 4'b0010, 1, 0, 0, 0, 0, m_tc, 4'b0);
    master_clear = 1; underflow = 1;
    cyc(1, 4'b0010, 4'b0010, 1, 0, 0, 0, 0, m_tc, 4'b0);
    master_clear = 0; underflow = 0; dma_request = 0; hold_acknowledge = 0;
    m_tc = 4'b0; m_ptr = 0;
    idle();
    xfer(4'b1111, 4'b0, 4'b0, 1, 4'b0, 0, 0, 0);

    // Randomized transfers.
    for (int n = 0; n < 40; n++) begin
      do begin
        dr = 4'($urandom);
        mk = 4'($urandom);
        sw = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      end while (((dr & ~mk) | sw) == 4'b0);
      xfer(dr, mk, sw, 1'($urandom), 4'($urandom), 1'($urandom),
           $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
